// File: rtl/board_debug_display.sv
// Multi-page 7-segment debug display: debounced page key, freeze snapshot, PC breakpoint with blink.
// Optional BOARD_DISP_AUTOSCROLL_EN: advance the page on every blink-counter wrap while live.
module board_debug_display #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned NUM_PAGES  = 4,
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned BLINK_BITS = 24,
    parameter int unsigned ROTATE     = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic [NUM_PAGES*NUM_DIGITS*4-1:0] i_page_data,
    input  logic                              i_key_next,
    input  logic                              i_freeze,
    input  logic                              i_bp_en,
    input  logic [15:0]                       i_bp_addr,
    input  logic [15:0]                       i_pc,
    input  logic                              i_pc_valid,
    output logic [NUM_DIGITS*7-1:0]           o_hex,
    output logic [$clog2(NUM_PAGES)-1:0]      o_page,
    output logic                              o_frozen,
    output logic                              o_bp_hit
);

    localparam int unsigned PAGE_W = NUM_DIGITS * 4;
    localparam int unsigned DATA_W = NUM_PAGES * PAGE_W;
    localparam int unsigned HEX_W  = NUM_DIGITS * 7;
    localparam int unsigned PG_W   = $clog2(NUM_PAGES);
    localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    function automatic logic [6:0] f_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Upside-down digit: a<->d, b<->e, c<->f, g stays.
    function automatic logic [6:0] f_rot(input logic [6:0] s);
        return {s[6], s[2], s[1], s[0], s[5], s[4], s[3]};
    endfunction

    function automatic logic [6:0] f_digit(input logic [PAGE_W-1:0] bits, input int unsigned d);
        logic [3:0] nib;
        nib = (ROTATE != 0) ? bits[4*(NUM_DIGITS-1-d) +: 4] : bits[4*d +: 4];
        return (ROTATE != 0) ? f_rot(f_seg(nib)) : f_seg(nib);
    endfunction

    logic                  r_key_m, r_key_s, r_deb, r_armed;
    logic [DEB_W-1:0]      r_deb_cnt;
    logic                  r_frz_m, r_frz_s;
    logic [PG_W-1:0]       r_page;
    logic                  r_bp_hit, r_frozen;
    logic [DATA_W-1:0]     r_snap;
    logic [BLINK_BITS-1:0] r_blink;
    logic [HEX_W-1:0]      r_hex;

    logic                  w_deb_flip, w_press, w_bp_match, w_bp_nxt, w_frozen_nxt, w_scroll, w_blank;
    logic [PG_W-1:0]       w_page_nxt;
    logic [DATA_W-1:0]     w_src;
    logic [PAGE_W-1:0]     w_page_bits;
    logic [HEX_W-1:0]      w_hex_nxt;

    assign w_deb_flip = (r_key_s != r_deb) && (r_deb_cnt == DEB_W'(DEB_CYCLES - 1));
    // A key held through reset stays unarmed until it has been seen released.
    assign w_press    = w_deb_flip & r_deb & r_armed;
    assign w_bp_match = i_bp_en & i_pc_valid & (i_pc == i_bp_addr);

`ifdef BOARD_DISP_AUTOSCROLL_EN
    assign w_scroll = (&r_blink) & ~r_frozen & ~w_press;
`else
    assign w_scroll = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_key_m   <= 1'b0;
            r_key_s   <= 1'b0;
            r_deb     <= 1'b1;
            r_armed   <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_key_m <= i_key_next;
            r_key_s <= r_key_m;
            r_armed <= r_armed | r_key_s;
            if (r_key_s == r_deb) begin
                r_deb_cnt <= '0;
            end else if (w_deb_flip) begin
                r_deb     <= r_key_s;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    // Breakpoint: disable clears, a hit beats a same-cycle press.
    always_comb begin
        w_bp_nxt = r_bp_hit;
        if (!i_bp_en)        w_bp_nxt = 1'b0;
        else if (w_bp_match) w_bp_nxt = 1'b1;
        else if (w_press)    w_bp_nxt = 1'b0;
    end

    always_comb begin
        w_page_nxt = r_page;
        if ((w_press & ~r_bp_hit) | w_scroll)
            w_page_nxt = (r_page == PG_W'(NUM_PAGES - 1)) ? '0 : r_page + PG_W'(1);
    end

    assign w_frozen_nxt = r_frz_s | w_bp_nxt;
    assign w_blank      = r_bp_hit & r_blink[BLINK_BITS-1];

    always_comb begin
        w_src       = r_frozen ? r_snap : i_page_data;
        w_page_bits = w_src[32'(r_page)*PAGE_W +: PAGE_W];
        w_hex_nxt   = '1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (!w_blank) w_hex_nxt[7*d +: 7] = f_digit(w_page_bits, d);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_frz_m  <= 1'b0;
            r_frz_s  <= 1'b0;
            r_page   <= '0;
            r_bp_hit <= 1'b0;
            r_frozen <= 1'b0;
            r_snap   <= '0;
            r_blink  <= '0;
            r_hex    <= '1;
        end else begin
            r_frz_m  <= i_freeze;
            r_frz_s  <= r_frz_m;
            r_page   <= w_page_nxt;
            r_bp_hit <= w_bp_nxt;
            r_frozen <= w_frozen_nxt;
            r_blink  <= r_blink + BLINK_BITS'(1);
            r_hex    <= w_hex_nxt;
            if (w_frozen_nxt & ~r_frozen) r_snap <= i_page_data;
        end
    end

    assign o_hex    = r_hex;
    assign o_page   = r_page;
    assign o_frozen = r_frozen;
    assign o_bp_hit = r_bp_hit;

endmodule

// File: tb/tb_board_debug_display.sv
// Bench for board_debug_display: two instances (ROTATE=0/1) against a cycle model built from segment letters.
module tb_board_debug_display;

    localparam int ND  = 8;
    localparam int NP  = 4;
    localparam int DEB = 4;
    localparam int BB  = 4;
    localparam int DW  = NP * ND * 4;
    localparam int HW  = ND * 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] page_data;
    logic          key_n, freeze, bp_en, pc_valid;
    logic [15:0]   bp_addr, pc;
    logic [HW-1:0] hex0, hex1;
    logic [1:0]    page0, page1;
    logic          frozen0, frozen1, bp0, bp1;

    always #5 clk = ~clk;

    board_debug_display #(.NUM_DIGITS(ND), .NUM_PAGES(NP), .DEB_CYCLES(DEB), .BLINK_BITS(BB), .ROTATE(0)) u_dut0 (
        .i_clk(clk), .i_rstn(rst_n), .i_page_data(page_data), .i_key_next(key_n), .i_freeze(freeze),
        .i_bp_en(bp_en), .i_bp_addr(bp_addr), .i_pc(pc), .i_pc_valid(pc_valid),
        .o_hex(hex0), .o_page(page0), .o_frozen(frozen0), .o_bp_hit(bp0));

    board_debug_display #(.NUM_DIGITS(ND), .NUM_PAGES(NP), .DEB_CYCLES(DEB), .BLINK_BITS(BB), .ROTATE(1)) u_dut1 (
        .i_clk(clk), .i_rstn(rst_n), .i_page_data(page_data), .i_key_next(key_n), .i_freeze(freeze),
        .i_bp_en(bp_en), .i_bp_addr(bp_addr), .i_pc(pc), .i_pc_valid(pc_valid),
        .o_hex(hex1), .o_page(page1), .o_frozen(frozen1), .o_bp_hit(bp1));

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Lit segments per hex glyph.
    string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] seg_of(input logic [3:0] v, input bit rot);
        logic [6:0] on;
        string s;
        on = '0;
        s = lit[v];
        for (int i = 0; i < s.len(); i++) begin
            int idx;
            idx = int'(s[i]) - 97;
            if (rot && idx < 6) idx = (idx + 3) % 6;
            on[idx] = 1'b1;
        end
        return ~on;
    endfunction

    function automatic logic [HW-1:0] page_hex(input logic [DW-1:0] data, input int pg, input bit rot);
        logic [HW-1:0] r;
        r = '1;
        for (int d = 0; d < ND; d++) begin
            int k;
            k = rot ? (ND - 1 - d) : d;
            r[7*d +: 7] = seg_of(data[pg*ND*4 + 4*k +: 4], rot);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model state
    logic [1:0]    m_ks, m_fs;
    int            m_cnt, m_page, m_blink;
    bit            m_deb, m_armed, m_bp, m_frozen;
    logic [DW-1:0] m_snap;
    logic [HW-1:0] m_hex0, m_hex1;

    task automatic m_reset();
        m_ks = '0; m_fs = '0; m_cnt = 0; m_deb = 1'b1; m_armed = 1'b0;
        m_page = 0; m_bp = 1'b0; m_frozen = 1'b0; m_blink = 0; m_snap = '0;
        m_hex0 = '1; m_hex1 = '1;
    endtask

    initial m_reset();

    always begin : model
        bit press, bp_n, fr_n;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_reset();
        end else begin
            if (m_bp && m_blink >= (1 << (BB - 1))) begin
                m_hex0 = '1;
                m_hex1 = '1;
            end else begin
                m_hex0 = page_hex(m_frozen ? m_snap : page_data, m_page, 1'b0);
                m_hex1 = page_hex(m_frozen ? m_snap : page_data, m_page, 1'b1);
            end
            press = 1'b0;
            if (m_ks[1] != m_deb) begin
                m_cnt++;
                if (m_cnt == DEB) begin
                    press = m_deb && m_armed;
                    m_deb = m_ks[1];
                    m_cnt = 0;
                end
            end else begin
                m_cnt = 0;
            end
            m_armed = m_armed | m_ks[1];
            if (!bp_en)                          bp_n = 1'b0;
            else if (pc_valid && pc == bp_addr)  bp_n = 1'b1;
            else if (press)                      bp_n = 1'b0;
            else                                 bp_n = m_bp;
            if (press && !m_bp) m_page = (m_page + 1) % NP;
`ifdef BOARD_DISP_AUTOSCROLL_EN
            else if (!press && !m_frozen && m_blink == (1 << BB) - 1) m_page = (m_page + 1) % NP;
`endif
            fr_n = m_fs[1] | bp_n;
            if (fr_n && !m_frozen) m_snap = page_data;
            m_bp     = bp_n;
            m_frozen = fr_n;
            m_blink  = (m_blink + 1) % (1 << BB);
            m_ks     = {m_ks[0], key_n};
            m_fs     = {m_fs[0], freeze};
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("hex_rot0", 64'(hex0), 64'(m_hex0));
            chk("hex_rot1", 64'(hex1), 64'(m_hex1));
            chk("page_rot0", 64'(page0), 64'(m_page));
            chk("page_rot1", 64'(page1), 64'(m_page));
            chk("frozen", 64'({frozen0, frozen1}), 64'({m_frozen, m_frozen}));
            chk("bp_hit", 64'({bp0, bp1}), 64'({m_bp, m_bp}));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_press();
        key_n = 1'b0;
        cycles(10);
        key_n = 1'b1;
        cycles(10);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_hex"}, 64'({hex0, 8'h00}) ^ 64'(hex1), 64'({{HW{1'b1}}, 8'h00}) ^ 64'({HW{1'b1}}));
        chk({nm, "_hex0"}, 64'(hex0), 64'({HW{1'b1}}));
        chk({nm, "_page"}, 64'({page0, page1}), 64'(0));
        chk({nm, "_flags"}, 64'({frozen0, frozen1, bp0, bp1}), 64'(0));
    endtask

    int            exp_page;
    int            blanks;
    int            key_hold;
    logic [DW-1:0] snap_tb;

    initial begin
        page_data = {$urandom, $urandom, $urandom, 32'h76543210};
        key_n = 1'b1; freeze = 1'b0; bp_en = 1'b0; pc_valid = 1'b0;
        bp_addr = 16'h8000; pc = 16'h0000;
        exp_page = 0;
        cycles(3);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        cmp_en = 1'b1;
        cycles(2);

        // Glyph pins: '0' on digit0 / upside-down digit7, '1' next to it.
        chk("pin_model_d0", 64'(m_hex0[6:0]), 64'(7'h40));
        chk("pin_dut_d0", 64'(hex0[6:0]), 64'(7'h40));
        chk("pin_dut_d1", 64'(hex0[13:7]), 64'(7'h79));
        chk("pin_rot_d7", 64'(hex1[55:49]), 64'(7'h40));
        chk("pin_rot_d6", 64'(hex1[48:42]), 64'(7'h4F));
        chk("pin_model_rot_d6", 64'(m_hex1[48:42]), 64'(7'h4F));

        key_n = 1'b0; cycles(3); key_n = 1'b1; cycles(10);
`ifndef BOARD_DISP_AUTOSCROLL_EN
        chk("short_press_ignored", 64'(page0), 64'(exp_page));
`endif
        do_press(); exp_page = 1;
`ifndef BOARD_DISP_AUTOSCROLL_EN
        chk("first_press", 64'(page0), 64'(exp_page));
`endif
        repeat (3) do_press();
        exp_page = 0;
`ifndef BOARD_DISP_AUTOSCROLL_EN
        chk("page_wrap", 64'(page0), 64'(exp_page));
`endif

        // Freeze path
        snap_tb = page_data;
        freeze = 1'b1;
        cycles(2);
        chk("frz_sync_early", 64'(frozen0), 64'(0));
        cycles(1);
        chk("frz_on", 64'(frozen0), 64'(1));
        page_data = {$urandom, $urandom, $urandom, $urandom};
        cycles(2);
`ifndef BOARD_DISP_AUTOSCROLL_EN
        chk("frz_hold_p0", 64'(hex0), 64'(page_hex(snap_tb, 0, 1'b0)));
`endif
        do_press(); exp_page = 1;
`ifndef BOARD_DISP_AUTOSCROLL_EN
        chk("frz_snap_p1", 64'(hex0), 64'(page_hex(snap_tb, 1, 1'b0)));
        chk("frz_snap_p1_rot", 64'(hex1), 64'(page_hex(snap_tb, 1, 1'b1)));
`endif
        freeze = 1'b0;
        cycles(5);
`ifndef BOARD_DISP_AUTOSCROLL_EN
        chk("live_again", 64'(hex0), 64'(page_hex(page_data, 1, 1'b0)));
`endif

        // Breakpoint: hit, blink, press-clear, hit+press, disable
        bp_en = 1'b1; pc = 16'h8000; pc_valid = 1'b1;
        cycles(1);
        pc_valid = 1'b0; pc = 16'h1234;
        chk("bp_hit_set", 64'({bp0, frozen0}), 64'(2'b11));
        blanks = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (hex0 == {HW{1'b1}}) blanks++;
        end
        chk("blink_blank_cycles", 64'(blanks), 64'(16));
        do_press();
        chk("bp_cleared_by_press", 64'({bp0, frozen0}), 64'(0));
`ifndef BOARD_DISP_AUTOSCROLL_EN
        chk("bp_press_page_same", 64'(page0), 64'(exp_page));
`endif
        pc = 16'h8000; pc_valid = 1'b1;
        do_press();
        chk("hit_beats_press", 64'(bp0), 64'(1));
        bp_en = 1'b0; pc_valid = 1'b0;
        cycles(1);
        chk("bp_en_clear", 64'({bp0, frozen0}), 64'(0));

        // Randomised traffic
        key_hold = 0;
        bp_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (key_hold == 0) begin
                key_n = ~key_n;
                key_hold = $urandom_range(1, 12);
            end else begin
                key_hold--;
            end
            if ($urandom_range(0, 49) == 0) freeze = ~freeze;
            if ($urandom_range(0, 59) == 0) bp_en = ($urandom_range(0, 3) != 0);
            pc_valid = ($urandom_range(0, 2) == 0);
            pc = ($urandom_range(0, 15) == 0) ? bp_addr : 16'($urandom);
            if ($urandom_range(0, 3) == 0) page_data[32*$urandom_range(0, 3) +: 32] = $urandom;
        end

        // Asynchronous reset mid-traffic with the key held through it
        @(negedge clk);
        key_n = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_reset");
        cycles(3);
        rst_n = 1'b1;
        cycles(20);
`ifndef BOARD_DISP_AUTOSCROLL_EN
        chk("held_key_no_event", 64'(page0), 64'(0));
`endif
        key_n = 1'b1;
        cycles(10);
        do_press();
`ifndef BOARD_DISP_AUTOSCROLL_EN
        chk("press_after_release", 64'(page0), 64'(1));
`endif
        freeze = 1'b0; bp_en = 1'b0; pc_valid = 1'b0;
        cycles(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_debug_display.md
Name: board_debug_display

Overview:
- Parametrised multi-page 7-segment debug display manager for the board front panel; successor to the fixed CPU-register light panel.
- Shows one of NUM_PAGES hex pages (CPU PC/SP/IR, PPU regs, mapper state, …) on NUM_DIGITS digits.
- Page is selected by a debounced pushbutton.
- Supports a freeze snapshot of all pages, plus a PC breakpoint that auto-freezes the display and blinks it.

Parameters:
- NUM_DIGITS, 8, number of 7-seg digits.
- NUM_PAGES, 4, number of selectable pages (>=2).
- DEB_CYCLES, 50000, cycles the key level must be stable before it is accepted.
- BLINK_BITS, 24, width of the free-running blink counter; blink period is 2^BLINK_BITS cycles.
- ROTATE, 1, 1 = digits mounted upside down (segment and digit order rotated 180°).

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  asynchronous active-low reset
- i_page_data  in  NUM_PAGES*NUM_DIGITS*4  page p = bits [p*NUM_DIGITS*4 +: NUM_DIGITS*4]; nibble k = [4k+:4]
- i_key_next  in  1  raw pushbutton, active low, asynchronous
- i_freeze  in  1  freeze switch, level, asynchronous
- i_bp_en  in  1  breakpoint enable
- i_bp_addr  in  16  breakpoint PC
- i_pc  in  16  CPU PC
- i_pc_valid  in  1  one-cycle strobe per opcode fetch
- o_hex  out  NUM_DIGITS*7  digit d = [7d+:7], {g,f,e,d,c,b,a}, active low
- o_page  out  $clog2(NUM_PAGES)  current page index
- o_frozen  out  1  display is showing the snapshot
- o_bp_hit  out  1  sticky breakpoint hit

Behaviour:
- Clock is i_clk; reset i_rstn is asynchronous, active low. All state is in the i_clk domain.
- Reset values:
  - o_hex all 7'h7F (blank), o_page 0, o_frozen 0, o_bp_hit 0.
  - Debounced key = 1 (released); debounce and blink counters 0; snapshot buffer 0.
- Key path:
  - 2-flop synchroniser feeds the debouncer.
  - The debounced level changes only after the synchronised level differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
  - A press event is a 1->0 transition of the debounced level; one event per press.
- Press event with o_bp_hit=0: o_page increments; NUM_PAGES-1 wraps to 0.
- Press event with o_bp_hit=1: clears o_bp_hit; o_page is unchanged.
- Breakpoint:
  - When i_bp_en & i_pc_valid & (i_pc==i_bp_addr), o_bp_hit=1 on the next cycle (sticky).
  - If a hit and a press event occur in the same cycle, set wins.
  - i_bp_en=0 clears o_bp_hit on the next cycle.
- Freeze:
  - i_freeze passes through a 2-flop synchroniser (frz_s).
  - o_frozen = frz_s | o_bp_hit (registered).
  - On the unfrozen->frozen transition, the whole i_page_data is captured into the snapshot buffer (NUM_PAGES*NUM_DIGITS*4 bits), using the value present in the cycle the condition becomes true.
  - If already frozen, a new freeze or hit does not recapture.
  - While frozen, page changes select pages from the snapshot; otherwise the display is live.
- Display pipeline:
  - Source nibble for digit d = nibble d (ROTATE=0) or nibble NUM_DIGITS-1-d (ROTATE=1) of the selected page.
  - The nibble is decoded to hex 0–F, active low. ROTATE=1 additionally swaps segments a<->d, b<->e, c<->f.
  - o_hex is registered: 1-cycle latency from i_page_data or o_page change to o_hex.
- Blink:
  - The BLINK_BITS counter free-runs and wraps.
  - While o_bp_hit=1 and the counter MSB=1, all digits are forced to 7'h7F.
- Reset mid-press or mid-freeze returns everything to reset values; a key still held after reset produces no event until it has been released and pressed again.

Optional Feature:
- BOARD_DISP_AUTOSCROLL_EN defined: when the blink counter wraps to 0 with o_frozen=0 and no press event in that cycle, o_page advances by one (same wrap rule). Key presses still work; scrolling stops while frozen.
- Undefined: o_page changes only on press events.

Test Plan:
- Reset with i_rstn=0 mid-traffic -> o_hex all 7'h7F, o_page 0, o_bp_hit 0, o_frozen 0 immediately (asynchronous).
- ROTATE=0, page0=32'h76543210 -> one cycle later digit0=7'h40 ('0') and digit1=7'h79 ('1'). With ROTATE=1 -> digit7 shows '0' with a/d, b/e, c/f swapped.
- DEB_CYCLES=4:
  - key low 3 cycles then high -> o_page stays 0.
  - key low 10 cycles -> o_page=1 exactly once.
  - 4 clean presses with NUM_PAGES=4 -> o_page back to 0.
- i_freeze=1 -> o_frozen=1 after 2 sync cycles + 1; change i_page_data -> o_hex unchanged; press -> shows the page1 snapshot values; i_freeze=0 -> live data again.
- BLINK_BITS=4, i_bp_en=1, i_bp_addr=16'h8000, i_pc_valid with i_pc=16'h8000 -> o_bp_hit=1 and o_frozen=1 next cycle; o_hex blanks during counter values 8–15. Press -> o_bp_hit=0, o_page unchanged. Hit and press in the same cycle -> o_bp_hit stays 1.
- BOARD_DISP_AUTOSCROLL_EN, BLINK_BITS=4, unfrozen -> o_page advances every 16 cycles; assert i_freeze -> o_page holds.
